nobl_sram_emu: RTL
==================

# nobl_sram_emu

Synthesizable responder for the NoBL/ZBT SRAM pin protocol, backed by on-chip block RAM. It sits on the SRAM side of the existing NoBL controller/FIFO path. It lets the external-memory FIFO run on boards or builds that have no ZBT part fitted, and it gives the controller a cycle-accurate, bit-true target in simulation. It models a pipelined NoBL device with a single clock domain and a split (non-tristate) data bus.

## Interface
Parameters:
- WIDTH, 18, data word width.
- DEPTH, 10, address bits; the array holds 2^DEPTH words.

Ports:
- clk  in  1  SRAM clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- RAM_A  in  DEPTH  address, sampled on load cycles.
- RAM_WEn  in  1  0 = write, 1 = read; sampled on load cycles.
- RAM_CENn  in  1  clock enable, active-low; 1 freezes all internal state.
- RAM_LDn  in  1  0 = load new address/op; 1 = burst advance.
- RAM_CE1n  in  1  chip select, active-low; sampled on load cycles.
- RAM_OEn  in  1  output enable, active-low; combinational gate on RAM_D_poe.
- RAM_D_pi  in  WIDTH  write data from the controller.
- RAM_D_po  out  WIDTH  read data to the controller.
- RAM_D_poe  out  1  read data is being driven.

## Operation
- Every sampling edge with RAM_CENn=0 is classified:
  - LOAD when RAM_LDn=0 and RAM_CE1n=0. It is a WRITE when RAM_WEn=0, otherwise a READ.
  - DESELECT when RAM_LDn=0 and RAM_CE1n=1.
  - ADVANCE when RAM_LDn=1.
- Edges with RAM_CENn=1 are STALL edges. The pipeline, burst address, the last-op type and output registers all hold.
- Three-stage pipeline. Each stage holds {valid, write, addr}.
- WRITE at edge k: RAM_D_pi is sampled at edge k+2 and committed to the array at edge k+2.
- READ at edge k: the array is read at edge k+1. RAM_D_po is registered at edge k+2 and held until the next non-stall edge.
- RAM_D_poe = (stage-2 op is a valid READ) AND NOT RAM_OEn.
- RAM_D_po keeps its last value when RAM_D_poe=0. It is never forced to X.
- Coherency:
  - A READ always returns the most recent WRITE to the same address in issue order, including writes still in flight.
  - Case: READ at k+1 follows WRITE at k to the same address. RAM_D_po at edge k+3 must be the RAM_D_pi sampled at edge k+2 (forwarding path).
  - All other orderings resolve through the array.
- DESELECT inserts an empty slot. RAM_D_poe is 0 two edges later.
- Address arithmetic is DEPTH bits wide and unsigned. No out-of-range condition exists.
- Reset (asserted at any time, including mid-burst or mid-write):
  - Clears all pipeline valids, burst address and RAM_D_po to 0. RAM_D_poe goes 0 immediately.
  - In-flight writes are discarded.
  - Array contents are not cleared.

## Timing
- Read latency: 2 non-stall edges, address to data.
- Write data lag: 2 non-stall edges, address to data.
- Stall edges do not count toward either latency.
- Back-to-back mixed READ/WRITE at full clock rate, with no dead cycles required. Turnaround is the controller's concern.
- Synchronous block-RAM read, read-first mode. The forwarding path resolves the same-edge collision.
- One array write port and one read port. No combinational path from RAM_A to RAM_D_po.

## Configuration
- NOBL_BURST_EN defined:
  - ADVANCE repeats the last LOAD's op type at the burst address.
  - Burst address = previous address with bits [1:0] incremented modulo 4. Upper bits are held (linear wrap within a 4-word group).
  - ADVANCE after DESELECT or after reset is an empty slot.
- NOBL_BURST_EN undefined:
  - ADVANCE is treated exactly as DESELECT.
  - The burst address register and its mux are not built.

## Test plan
- Reset, then WRITE A=0x005 data 0x2A5A5; READ A=0x005 four edges later -> RAM_D_po=0x2A5A5 with RAM_D_poe=1 for exactly one edge, two edges after the READ.
- WRITE A=0x010 data 0x11111 at edge k, READ A=0x010 at k+1 -> RAM_D_po=0x11111 after edge k+3 (forwarding, not stale array data).
- READ A=0x020 with RAM_CENn=1 for 3 edges inserted after the load -> data appears after the 2nd non-stall edge; RAM_D_po stable throughout the stall.
- NOBL_BURST_EN on: LOAD READ A=0x3E6, then three ADVANCE -> data from addresses 0x3E6, 0x3E7, 0x3E4, 0x3E5 on consecutive edges. NOBL_BURST_EN off: same stimulus -> one word only, RAM_D_poe=0 for the three following slots.
- RAM_OEn=1 during a READ return slot -> RAM_D_poe=0; RAM_D_po still updates to the read data.
- Assert rst_n=0 one edge after a WRITE load, release, then READ that address -> old array value returned; RAM_D_poe=0 and RAM_D_po=0 while rst_n=0.

Source files
------------

// File: rtl/nobl_sram_emu.sv
// nobl_sram_emu: block-RAM backed pipelined NoBL/ZBT SRAM responder; define NOBL_BURST_EN for linear 4-word bursts.
module nobl_sram_emu #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] RAM_A,
    input  logic             RAM_WEn,
    input  logic             RAM_CENn,
    input  logic             RAM_LDn,
    input  logic             RAM_CE1n,
    input  logic             RAM_OEn,
    input  logic [WIDTH-1:0] RAM_D_pi,
    output logic [WIDTH-1:0] RAM_D_po,
    output logic             RAM_D_poe
);
    logic [WIDTH-1:0] mem [2**DEPTH];
    logic [2:0] v_q, v_d, w_q, w_d;
    logic [1:0][DEPTH-1:0] a_q, a_d;
    logic hit_q, hit_d;
    logic [WIDTH-1:0] fwd_q, fwd_d, po_q, po_d, rd_q;
    logic sel, new_v, new_w;
    logic [DEPTH-1:0] new_a;
`ifdef NOBL_BURST_EN
    logic bv_q, bv_d, bw_q, bw_d;
    logic [DEPTH-1:0] ba_q, ba_d;
`endif

    // Slot classification, pipeline shift, and the write-to-read collision capture
    always_comb begin
        sel = !RAM_LDn && !RAM_CE1n;
`ifdef NOBL_BURST_EN
        new_v = sel || (RAM_LDn && bv_q);
        new_w = sel ? !RAM_WEn : bw_q;
        new_a = sel ? RAM_A : {ba_q[DEPTH-1:2], ba_q[1:0] + 2'd1};
        bv_d = (RAM_CENn || RAM_LDn) ? bv_q : sel;
        bw_d = (RAM_CENn || !new_v) ? bw_q : new_w;
        ba_d = (RAM_CENn || !new_v) ? ba_q : new_a;
`else
        new_v = sel;
        new_w = !RAM_WEn;
        new_a = RAM_A;
`endif
        v_d = RAM_CENn ? v_q : {v_q[1:0], new_v};
        w_d = RAM_CENn ? w_q : {w_q[1:0], new_w};
        a_d = RAM_CENn ? a_q : {a_q[0], new_a};
        hit_d = RAM_CENn ? hit_q : (v_q[1] && w_q[1] && v_q[0] && !w_q[0] && a_q[1] == a_q[0]);
        fwd_d = RAM_CENn ? fwd_q : RAM_D_pi;
        po_d = (RAM_CENn || !v_q[1] || w_q[1]) ? po_q : (hit_q ? fwd_q : rd_q);
    end

    // Pipeline and output registers; reset drops in-flight ops but leaves the array alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            w_q   <= '0;
            a_q   <= '0;
            hit_q <= 1'b0;
            fwd_q <= '0;
            po_q  <= '0;
`ifdef NOBL_BURST_EN
            bv_q  <= 1'b0;
            bw_q  <= 1'b0;
            ba_q  <= '0;
`endif
        end else begin
            v_q   <= v_d;
            w_q   <= w_d;
            a_q   <= a_d;
            hit_q <= hit_d;
            fwd_q <= fwd_d;
            po_q  <= po_d;
`ifdef NOBL_BURST_EN
            bv_q  <= bv_d;
            bw_q  <= bw_d;
            ba_q  <= ba_d;
`endif
        end
    end

    // Block RAM: read-first synchronous read for stage 0, write commit for stage 1
    always_ff @(posedge clk) begin
        if (!RAM_CENn) begin
            rd_q <= mem[a_q[0]];
            if (v_q[1] && w_q[1]) mem[a_q[1]] <= RAM_D_pi;
        end
    end

    assign RAM_D_po  = po_q;
    assign RAM_D_poe = v_q[2] && !w_q[2] && !RAM_OEn;
endmodule
